aim_step_scheduler: RTL and testbench

// Shares the Control block's 2-bit ctl input between two requesters: player input (port p_*) and auto/demo source (a_*).

---
 rtl/aim_step_scheduler_pkg.sv | 36 +++
 rtl/aim_step_scheduler_step_timer.sv | 34 +++
 rtl/aim_step_scheduler.sv | 134 +++++++++++++
 tb/tb_aim_step_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aim_step_scheduler_pkg.sv
// Shared definitions for the aim step scheduler: ctl command encodings, FSM
// state codes and the aim limit check used during arbitration.
package aim_step_scheduler_pkg;

    // ctl command encoding, shared with the Control block.
    typedef enum logic [1:0] {
        CtlNone   = 2'b00,
        CtlDec    = 2'b01,
        CtlInc    = 2'b10,
        CtlCentre = 2'b11
    } ctl_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StHold  = 2'b10
    } state_e;

    // A command is legal when it moves aim without crossing a limit.
    // CENTRE is always legal; NONE never is.
    function automatic logic dir_legal(input ctl_e       dir,
                                       input logic [7:0] aim,
                                       input logic [7:0] aim_min,
                                       input logic [7:0] aim_max);
        logic ok;
        ok = 1'b0;
        case (dir)
            CtlCentre: ok = 1'b1;
            CtlInc:    ok = (aim < aim_max);
            CtlDec:    ok = (aim > aim_min);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/aim_step_scheduler_step_timer.sv
// Loadable down-counter that times the hold-off after each issued step.
// Counts down to zero and stays there; done_o is high while the count is zero.
module aim_step_scheduler_step_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] count_d, count_q;

    // Next count: clear wins over load, load wins over decrement.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/aim_step_scheduler.sv
// Arbitrates player and auto step requests onto the Control block's ctl input.
// One command per grant, emitted as a single-cycle ctl pulse, followed by a
// hold-off so pulses are at least StepDiv cycles apart. Player has priority
// unless auto has been passed over StarveMax times in a row.
module aim_step_scheduler
    import aim_step_scheduler_pkg::*;
#(
    parameter int unsigned StepDiv   = 20,
    parameter int unsigned StarveMax = 4,
    parameter logic [7:0]  AimMin    = 8'h00,
    parameter logic [7:0]  AimMax    = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       p_req_i,
    input  logic [1:0] p_dir_i,
    input  logic       a_req_i,
    input  logic [1:0] a_dir_i,
    input  logic [7:0] aim_pos_i,
    output logic [1:0] ctl_o,
    output logic       p_ack_o,
    output logic       a_ack_o,
    output logic       rej_o,
    output logic       busy_o
);

    localparam int unsigned TimerW  = (StepDiv > 2) ? $clog2(StepDiv) : 1;
    localparam int unsigned StarveW = $clog2(StarveMax + 1);

    state_e               state_d, state_q;
    ctl_e                 ctl_d, ctl_q;
    logic                 p_ack_d, p_ack_q;
    logic                 a_ack_d, a_ack_q;
    logic                 rej_d, rej_q;
    logic                 busy_d, busy_q;
    logic [StarveW-1:0]   starve_d, starve_q;

    logic                 p_win;
    ctl_e                 win_dir;
    logic                 win_legal;
    logic                 timer_load;
    logic                 timer_done;

    // ISSUE plus HOLD last StepDiv-1 cycles; the deciding IDLE cycle makes StepDiv.
    aim_step_scheduler_step_timer #(
        .Width (TimerW)
    ) u_step_timer (
        .clk_i      (clk_i),
        .clr_i      (rst_i),
        .load_i     (timer_load),
        .load_val_i (TimerW'(StepDiv - 2)),
        .done_o     (timer_done)
    );

    // Arbitration, limit check, starvation tracking and FSM next state.
    always_comb begin
        state_d    = state_q;
        ctl_d      = CtlNone;
        p_ack_d    = 1'b0;
        a_ack_d    = 1'b0;
        rej_d      = 1'b0;
        starve_d   = starve_q;
        timer_load = 1'b0;

        p_win     = p_req_i && (!a_req_i || (starve_q < StarveW'(StarveMax)));
        win_dir   = p_win ? ctl_e'(p_dir_i) : ctl_e'(a_dir_i);
        win_legal = dir_legal(win_dir, aim_pos_i, AimMin, AimMax);

        case (state_q)
            StIdle: begin
                if (p_req_i || a_req_i) begin
                    p_ack_d = p_win;
                    a_ack_d = !p_win;
                    // Rejected grants count toward starvation like issued ones.
                    if (p_win && a_req_i) begin
                        if (starve_q < StarveW'(StarveMax)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                    if (win_legal) begin
                        state_d    = StIssue;
                        ctl_d      = win_dir;
                        timer_load = 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = timer_done ? StIdle : StHold;
            end
            StHold: begin
                if (timer_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ctl_q    <= CtlNone;
            p_ack_q  <= 1'b0;
            a_ack_q  <= 1'b0;
            rej_q    <= 1'b0;
            busy_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            p_ack_q  <= p_ack_d;
            a_ack_q  <= a_ack_d;
            rej_q    <= rej_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    assign ctl_o   = ctl_q;
    assign p_ack_o = p_ack_q;
    assign a_ack_o = a_ack_q;
    assign rej_o   = rej_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_aim_step_scheduler.sv
// Scoreboard bench for aim_step_scheduler: a timing-level reference model
// predicts each ack/ctl response and the busy window; a monitor compares.
module tb_aim_step_scheduler;

    localparam int STEP_DIV   = 20;
    localparam int STARVE_MAX = 4;
    localparam int AIM_MIN    = 0;
    localparam int AIM_MAX    = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_req = 1'b0;
    logic [1:0] p_dir = 2'b00;
    logic       a_req = 1'b0;
    logic [1:0] a_dir = 2'b00;
    logic [7:0] aim_pos = 8'h40;
    logic [1:0] ctl;
    logic       p_ack, a_ack, rej, busy;

    aim_step_scheduler dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .p_req_i   (p_req),
        .p_dir_i   (p_dir),
        .a_req_i   (a_req),
        .a_dir_i   (a_dir),
        .aim_pos_i (aim_pos),
        .ctl_o     (ctl),
        .p_ack_o   (p_ack),
        .a_ack_o   (a_ack),
        .rej_o     (rej),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [4:0] vec;   // {p_ack, a_ack, rej, ctl}
    } exp_t;

    typedef struct {
        int   at;
        logic who_p;
    } pulse_t;

    exp_t   exp_q[$];
    pulse_t log_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Model state: earliest edge a decision may be made, starvation count,
    // and the window of sample cycles in which busy is expected high.
    int next_free = 0;
    int starve = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    logic p_granted = 1'b0;
    logic a_granted = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model for the edge about to happen.
    task automatic model_edge();
        int   k;
        logic pw;
        int   d;
        int   aim;
        logic legal;
        exp_t e;
        k = cyc + 1;
        if (rst) begin
            starve    = 0;
            next_free = k + 1;
            busy_lo   = 1;
            busy_hi   = 0;
            return;
        end
        if (k >= next_free && (p_req || a_req)) begin
            pw    = p_req && (!a_req || starve < STARVE_MAX);
            d     = pw ? int'(p_dir) : int'(a_dir);
            aim   = int'(aim_pos);
            legal = (d == 3) || (d == 2 && aim < AIM_MAX) || (d == 1 && aim > AIM_MIN);
            e.at  = k;
            e.vec = {pw, !pw, !legal, legal ? 2'(d) : 2'b00};
            exp_q.push_back(e);
            if (pw && a_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else starve = 0;
            if (legal) begin
                next_free = k + STEP_DIV;
                busy_lo   = k;
                busy_hi   = k + STEP_DIV - 2;
            end else begin
                next_free = k + 1;
            end
            if (pw) p_granted = 1'b1;
            else a_granted = 1'b1;
        end
    endtask

    // A granted requester deasserts in the cycle after its ack.
    task automatic tick();
        model_edge();
        @(negedge clk);
        if (p_granted) begin
            p_req = 1'b0;
            p_granted = 1'b0;
        end
        if (a_granted) begin
            a_req = 1'b0;
            a_granted = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        p_req = 1'b0;
        a_req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare every presented response against the scoreboard.
    always @(posedge clk) begin
        logic [4:0] act;
        logic       exp_busy;
        #1;
        act = {p_ack, a_ack, rej, ctl};
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_resp cyc=%0d: got none, required %b at %0d",
                     cyc, exp_q[0].vec, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (act != 5'b0) begin
            checks++;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                if (act !== exp_q[0].vec) begin
                    errors++;
                    $display("FAIL resp cyc=%0d: got %b, required %b", cyc, act, exp_q[0].vec);
                end
                void'(exp_q.pop_front());
            end else begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d: got %b, required 00000", cyc, act);
            end
            if (ctl != 2'b00) begin
                log_q.push_back('{at: cyc, who_p: p_ack});
            end
        end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_resp cyc=%0d: got 00000, required %b", cyc, exp_q[0].vec);
            void'(exp_q.pop_front());
        end
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, exp_busy);
        end
    end

    initial begin
        @(negedge clk);

        // Reset held two cycles with a request present, then it is granted.
        rst = 1'b1; p_req = 1'b1; p_dir = 2'b10; aim_pos = 8'h40;
        tick(); tick();
        rst = 1'b0;
        tick();
        idle(25);

        // Single step then an immediate follow-up request.
        p_req = 1'b1; p_dir = 2'b10;
        tick();
        for (int i = 0; i < 25; i++) begin
            if (!p_req) begin
                p_req = 1'b1;
                p_dir = 2'b01;
            end
            tick();
        end
        idle(25);

        // Limit rejections.
        aim_pos = 8'h00; a_req = 1'b1; a_dir = 2'b01;
        tick(); idle(3);
        aim_pos = 8'hFF; p_req = 1'b1; p_dir = 2'b10;
        tick(); idle(3);

        // Fairness with both requesters held.
        rst = 1'b1; tick(); rst = 1'b0;
        log_q.delete();
        aim_pos = 8'h80;
        for (int i = 0; i < 205; i++) begin
            p_req = 1'b1; p_dir = 2'b10;
            a_req = 1'b1; a_dir = 2'b01;
            tick();
        end
        idle(25);
        checks++;
        if (log_q.size() < 10) begin
            errors++;
            $display("FAIL fair_count: got %0d pulses, required >= 10", log_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                logic want_p;
                want_p = ((i % 5) != 4);
                checks++;
                if (log_q[i].who_p !== want_p) begin
                    errors++;
                    $display("FAIL fair_order[%0d]: got player=%b, required player=%b",
                             i, log_q[i].who_p, want_p);
                end
                if (i > 0) begin
                    checks++;
                    if (log_q[i].at - log_q[i-1].at != STEP_DIV) begin
                        errors++;
                        $display("FAIL fair_spacing[%0d]: got %0d, required %0d",
                                 i, log_q[i].at - log_q[i-1].at, STEP_DIV);
                    end
                end
            end
        end

        // Reset during HOLD with a pending request.
        aim_pos = 8'h40; p_req = 1'b1; p_dir = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) tick();
        p_req = 1'b1; p_dir = 2'b01; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        idle(25);

        // CENTRE at the upper limit, then NONE.
        aim_pos = 8'hFF; p_req = 1'b1; p_dir = 2'b11;
        tick(); idle(22);
        p_req = 1'b1; p_dir = 2'b00;
        tick(); idle(3);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if (!p_req && $urandom_range(0, 3) == 0) begin
                p_req = 1'b1; p_dir = 2'($urandom_range(0, 3));
            end else if (p_req && $urandom_range(0, 39) == 0) begin
                p_req = 1'b0;
            end
            if (!a_req && $urandom_range(0, 3) == 0) begin
                a_req = 1'b1; a_dir = 2'($urandom_range(0, 3));
            end else if (a_req && $urandom_range(0, 39) == 0) begin
                a_req = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: aim_pos = 8'h00;
                    1: aim_pos = 8'hFF;
                    2: aim_pos = 8'h01;
                    3: aim_pos = 8'hFE;
                    default: aim_pos = 8'($urandom_range(0, 255));
                endcase
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        idle(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
